// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stage indices for the pipeline hazard-control block.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int IF_STG  = 0;
    localparam int ID_STG  = 1;
    localparam int EX_STG  = 2;
    localparam int MEM_STG = 3;
    localparam int WB_STG  = 4;

endpackage

// File: rtl/prio_msb_enc.sv
// Highest-set-bit priority encoder; valid is low when no bit is set.
module prio_msb_enc #(
    parameter int W     = 5,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Ascending scan so the last hit, the highest bit, wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (req[i]) begin
                idx   = i[IDX_W-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Merges per-stage stall/flush requests into PC and pipeline-register controls,
// with a halt/drain/resume sequence, a stall watchdog and performance counters.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32,
    parameter int MAX_STALL  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic [NUM_STAGES-1:0] flush_req,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  pc_enable,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic                  halted,
    output logic                  watchdog_err,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    state_t           state;
    logic [IDX_W-1:0] drain_cnt;
    logic [7:0]       stall_run;

    logic [IDX_W-1:0] s_idx;
    logic [IDX_W-1:0] f_idx;
    logic             s_valid;
    logic             f_valid;
    logic             stall_active;
    logic             flush_applied;

    prio_msb_enc #(.W(NUM_STAGES), .IDX_W(IDX_W)) u_stall_enc (
        .req   (stall_req),
        .idx   (s_idx),
        .valid (s_valid)
    );

    prio_msb_enc #(.W(NUM_STAGES), .IDX_W(IDX_W)) u_flush_enc (
        .req   (flush_req),
        .idx   (f_idx),
        .valid (f_valid)
    );

    // A stall at or above the flushing stage wins; the flush requester must hold its request
    always_comb begin
        pc_enable     = 1'b0;
        stage_en      = '1;
        stage_flush   = '0;
        halted        = 1'b0;
        stall_active  = 1'b0;
        flush_applied = 1'b0;
        if (!rst_n) begin
            stage_flush = '1;
        end else begin
            case (state)
                RUN: begin
                    pc_enable = 1'b1;
                    if (s_valid && (!f_valid || (s_idx >= f_idx))) begin
                        stall_active = 1'b1;
                        pc_enable    = 1'b0;
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (i < int'(s_idx)) begin
                                stage_en[i] = 1'b0;
                            end
                        end
                        stage_flush[s_idx] = 1'b1;
                    end else if (f_valid) begin
                        flush_applied = 1'b1;
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (i < int'(f_idx)) begin
                                stage_flush[i] = 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    stage_flush[IF_STG] = 1'b1;
                end
                HALTED: begin
                    stage_en = '0;
                    halted   = 1'b1;
                end
                default: begin
                    stage_flush = '1;
                end
            endcase
        end
    end

    // Drain pushes bubbles in at IF until every older instruction has retired
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req) begin
                        state     <= DRAIN;
                        drain_cnt <= IDX_W'(NUM_STAGES - 1);
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - 1'b1;
                    if (drain_cnt == IDX_W'(1)) begin
                        state <= HALTED;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Error latches on the same edge that stall_run reaches the limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_run    <= '0;
            watchdog_err <= 1'b0;
        end else if (stall_active) begin
            if (stall_run != 8'(MAX_STALL)) begin
                stall_run <= stall_run + 8'd1;
            end
            if (stall_run >= 8'(MAX_STALL - 1)) begin
                watchdog_err <= 1'b1;
            end
        end else begin
            stall_run <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_active && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (flush_applied && (flush_events != '1)) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end

endmodule
